// File: rtl/rapids_pkg.sv
// rapids_pkg: shared definitions for the rapids core integration blocks.
// Holds the run-controller state encoding and the default word/address/register
// widths that the mmu, decode and run-control blocks agree on.
package rapids_pkg;

  localparam int RAPIDS_ADDR_W = 8;
  localparam int RAPIDS_DATA_W = 32;
  localparam int RAPIDS_REG_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_GO,
    ST_RUN,
    ST_CHK_REQ,
    ST_CHK_CMP,
    ST_DONE
  } run_state_e;

  // The core is held in reset until the image has fully landed in memory.
  function automatic logic holdsCore(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_FLUSH);
  endfunction

  function automatic logic isBusyState(input run_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/rapids_chk_unit.sv
// rapids_chk_unit: register-check datapath of the run controller.
// Accepts one (register, expected value) entry per request cycle, reads the
// register file and compares on the following cycle, counting mismatches with
// saturation and remembering the register index of the first mismatch.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear_i           start of a new sequence: zero the counter and first-fail index
//   req_i / cmp_i     controller is in CHK_REQ / CHK_CMP
//   chk_valid_i, chk_idx_i, chk_expect_i, chk_last_i   check entry stream
//   reg_rd_data_i     register-file data, one cycle after the read index
//   chk_ready_o       entry accepted this cycle
//   reg_rd_idx_o      register-file read index
//   fail_count_o, first_fail_idx_o   mismatch results
//   last_o            the entry being compared is the final one
module rapids_chk_unit
  import rapids_pkg::*;
#(
  parameter int DATA_W = RAPIDS_DATA_W,
  parameter int REG_W  = RAPIDS_REG_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              req_i,
  input  logic              cmp_i,
  input  logic              chk_valid_i,
  input  logic [REG_W-1:0]  chk_idx_i,
  input  logic [DATA_W-1:0] chk_expect_i,
  input  logic              chk_last_i,
  input  logic [DATA_W-1:0] reg_rd_data_i,
  output logic              chk_ready_o,
  output logic [REG_W-1:0]  reg_rd_idx_o,
  output logic [CNT_W-1:0]  fail_count_o,
  output logic [REG_W-1:0]  first_fail_idx_o,
  output logic              last_o
);

  logic [REG_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] expect_q, expect_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  failCnt_q, failCnt_d;
  logic [REG_W-1:0]  firstFail_q, firstFail_d;
  logic              fire;
  logic              mismatch;

  // The read index is driven straight from chk_idx during the handshake so the
  // synchronous register-file read returns its data in the compare cycle.
  always_comb begin
    fire         = req_i && chk_valid_i;
    mismatch     = cmp_i && (reg_rd_data_i != expect_q);
    idx_d        = idx_q;
    expect_d     = expect_q;
    last_d       = last_q;
    failCnt_d    = failCnt_q;
    firstFail_d  = firstFail_q;
    chk_ready_o  = req_i;
    reg_rd_idx_o = req_i ? chk_idx_i : idx_q;
    if (fire) begin
      idx_d    = chk_idx_i;
      expect_d = chk_expect_i;
      last_d   = chk_last_i;
    end
    if (clear_i) begin
      failCnt_d   = '0;
      firstFail_d = '0;
    end else if (mismatch) begin
      if (failCnt_q == '0) begin
        firstFail_d = idx_q;
      end
      if (failCnt_q != '1) begin
        failCnt_d = failCnt_q + CNT_W'(1);
      end
    end
  end

  // Entry latches and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      expect_q    <= '0;
      last_q      <= 1'b0;
      failCnt_q   <= '0;
      firstFail_q <= '0;
    end else begin
      idx_q       <= idx_d;
      expect_q    <= expect_d;
      last_q      <= last_d;
      failCnt_q   <= failCnt_d;
      firstFail_q <= firstFail_d;
    end
  end

  assign fail_count_o     = failCnt_q;
  assign first_fail_idx_o = firstFail_q;
  assign last_o           = last_q;

endmodule

// File: rtl/rapids_run_ctrl.sv
// rapids_run_ctrl: load/run/check sequencer for the rapids core.
// Streams a program image into core memory while holding the core in reset,
// pulses go, waits for halt or the cycle budget, then checks a list of
// (register, expected value) pairs against the register file.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start                          begin a sequence (honoured in IDLE/DONE only)
//   ld_valid/ld_ready/ld_data/ld_last        program word stream
//   mem_we/mem_addr/mem_wdata      core memory write port (registered)
//   cpu_reset, cpu_go, cpu_halted  core control
//   chk_valid/chk_ready/chk_idx/chk_expect/chk_last   check entry stream
//   reg_rd_idx, reg_rd_data        register-file read port
//   busy, done, pass, timed_out, load_trunc, fail_count, first_fail_idx  status
module rapids_run_ctrl
  import rapids_pkg::*;
#(
  parameter int ADDR_W     = RAPIDS_ADDR_W,
  parameter int DATA_W     = RAPIDS_DATA_W,
  parameter int PROG_DEPTH = 64,
  parameter int REG_W      = RAPIDS_REG_W,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              cpu_go,
  input  logic              cpu_halted,
  input  logic              chk_valid,
  output logic              chk_ready,
  input  logic [REG_W-1:0]  chk_idx,
  input  logic [DATA_W-1:0] chk_expect,
  input  logic              chk_last,
  output logic [REG_W-1:0]  reg_rd_idx,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic              load_trunc,
  output logic [CNT_W-1:0]  fail_count,
  output logic [REG_W-1:0]  first_fail_idx
);

  // The timer never runs past TIMEOUT-1, so it only needs to hold that value.
  localparam int TMR_W = $clog2(TIMEOUT);

  run_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              timedOut_q, timedOut_d;
  logic              loadTrunc_q, loadTrunc_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic              clearRun;
  logic              chkLast;

  rapids_chk_unit #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (clearRun),
    .req_i            (state_q == ST_CHK_REQ),
    .cmp_i            (state_q == ST_CHK_CMP),
    .chk_valid_i      (chk_valid),
    .chk_idx_i        (chk_idx),
    .chk_expect_i     (chk_expect),
    .chk_last_i       (chk_last),
    .reg_rd_data_i    (reg_rd_data),
    .chk_ready_o      (chk_ready),
    .reg_rd_idx_o     (reg_rd_idx),
    .fail_count_o     (fail_count),
    .first_fail_idx_o (first_fail_idx),
    .last_o           (chkLast)
  );

  // Sequencer next-state logic. The write port is registered so each accepted
  // word appears on mem_we exactly one cycle after its handshake; the word at
  // PROG_DEPTH-1 always closes the load even without ld_last.
  always_comb begin
    state_d     = state_q;
    addrCnt_d   = addrCnt_q;
    timer_d     = timer_q;
    timedOut_d  = timedOut_q;
    loadTrunc_d = loadTrunc_q;
    memWe_d     = 1'b0;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    clearRun    = 1'b0;
    ld_ready    = 1'b0;
    cpu_go      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          addrCnt_d   = '0;
          timer_d     = '0;
          timedOut_d  = 1'b0;
          loadTrunc_d = 1'b0;
          clearRun    = 1'b1;
        end
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          memWe_d    = 1'b1;
          memAddr_d  = addrCnt_q;
          memWdata_d = ld_data;
          addrCnt_d  = addrCnt_q + ADDR_W'(1);
          if (ld_last) begin
            state_d = ST_FLUSH;
          end else if (addrCnt_q == ADDR_W'(PROG_DEPTH - 1)) begin
            state_d     = ST_FLUSH;
            loadTrunc_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_GO;
      end
      ST_GO: begin
        cpu_go  = 1'b1;
        timer_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        timer_d = timer_q + TMR_W'(1);
        if (cpu_halted) begin
          state_d = ST_CHK_REQ;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          timedOut_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_CHK_REQ: begin
        if (chk_valid) begin
          state_d = ST_CHK_CMP;
        end
      end
      ST_CHK_CMP: begin
        state_d = chkLast ? ST_DONE : ST_CHK_REQ;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and the registered memory write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addrCnt_q   <= '0;
      timer_q     <= '0;
      timedOut_q  <= 1'b0;
      loadTrunc_q <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      addrCnt_q   <= addrCnt_d;
      timer_q     <= timer_d;
      timedOut_q  <= timedOut_d;
      loadTrunc_q <= loadTrunc_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
    end
  end

  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign cpu_reset  = holdsCore(state_q);
  assign busy       = isBusyState(state_q);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && !timedOut_q && (fail_count == '0);
  assign timed_out  = timedOut_q;
  assign load_trunc = loadTrunc_q;

endmodule

// File: tb/tb_rapids_run_ctrl.sv
// tb_rapids_run_ctrl: scoreboard bench for rapids_run_ctrl.
// Stimulus pushes expected memory writes and end-of-run results into queues;
// a negedge monitor pops and compares as the DUT produces them.
module tb_rapids_run_ctrl;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int PROG_DEPTH = 8;
  localparam int REG_W      = 4;
  localparam int TIMEOUT    = 16;
  localparam int CNT_W      = 3;
  localparam int SAT        = (1 << CNT_W) - 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] expv;
  } chk_t;

  typedef struct {
    bit pass;
    bit tmo;
    bit trunc;
    int fails;
    int first;
    int writes;
    int latency;
  } res_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_reset;
  logic              cpu_go;
  logic              cpu_halted = 1'b0;
  logic              chk_valid = 1'b0;
  logic              chk_ready;
  logic [REG_W-1:0]  chk_idx = '0;
  logic [DATA_W-1:0] chk_expect = '0;
  logic              chk_last = 1'b0;
  logic [REG_W-1:0]  reg_rd_idx;
  logic [DATA_W-1:0] reg_rd_data = '0;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timed_out;
  logic              load_trunc;
  logic [CNT_W-1:0]  fail_count;
  logic [REG_W-1:0]  first_fail_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] prog [$];
  bit                progHasLast;
  chk_t              chkList [$];
  int                haltAt = -1;
  bit                startDuringRun = 0;
  wr_t               writeQ [$];
  res_t              resultQ [$];

  rapids_run_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .PROG_DEPTH (PROG_DEPTH),
    .REG_W      (REG_W),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .cpu_reset      (cpu_reset),
    .cpu_go         (cpu_go),
    .cpu_halted     (cpu_halted),
    .chk_valid      (chk_valid),
    .chk_ready      (chk_ready),
    .chk_idx        (chk_idx),
    .chk_expect     (chk_expect),
    .chk_last       (chk_last),
    .reg_rd_idx     (reg_rd_idx),
    .reg_rd_data    (reg_rd_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timed_out      (timed_out),
    .load_trunc     (load_trunc),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file with a one-cycle synchronous read.
  always @(posedge clk) reg_rd_data <= regs[reg_rd_idx];

  // Core model: halts haltAt run cycles after go (haltAt < 0 never halts).
  int  goCnt = 0;
  bit  running = 0;
  always @(negedge clk) begin
    if (cpu_reset) begin
      running    = 0;
      cpu_halted = 1'b0;
    end else begin
      if (cpu_go) begin
        running = 1;
        goCnt   = 0;
      end else if (running) begin
        goCnt++;
      end
      cpu_halted = running && (haltAt >= 0) && (goCnt >= haltAt + 1);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops expected writes as mem_we appears and expected results at done.
  int   writesSeen = 0;
  int   chkRdyCnt = 0;
  int   goCyc = 0;
  bit   doneSeen = 0;
  bit   prevBusy = 0;
  wr_t  w;
  res_t r;
  always @(negedge clk) begin
    if (reset) begin
      writesSeen = 0;
      chkRdyCnt  = 0;
      doneSeen   = 0;
      prevBusy   = 0;
    end else begin
      if (busy && !prevBusy) begin
        writesSeen = 0;
        chkRdyCnt  = 0;
      end
      if (mem_we) begin
        writesSeen++;
        checkOutput("write_cpu_reset_held", cpu_reset, 1);
        if (writeQ.size() == 0) begin
          checkOutput("write_unexpected", 1, 0);
        end else begin
          w = writeQ.pop_front();
          checkOutput("write_addr", mem_addr, w.addr);
          checkOutput("write_data", mem_wdata, w.data);
        end
      end
      if (cpu_go) goCyc = cyc;
      if (chk_ready) chkRdyCnt++;
      if (done && !doneSeen) begin
        doneSeen = 1;
        if (resultQ.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          r = resultQ.pop_front();
          checkOutput("pass", pass, r.pass);
          checkOutput("timed_out", timed_out, r.tmo);
          checkOutput("load_trunc", load_trunc, r.trunc);
          checkOutput("fail_count", fail_count, r.fails);
          checkOutput("first_fail_idx", first_fail_idx, r.first);
          checkOutput("write_count", writesSeen, r.writes);
          checkOutput("busy_at_done", busy, 0);
          if (r.latency >= 0) checkOutput("go_to_done_cycles", cyc - goCyc, r.latency);
          if (r.tmo) checkOutput("chk_ready_cycles_on_timeout", chkRdyCnt, 0);
        end
      end
      if (!done) doneSeen = 0;
      prevBusy = busy;
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_cpu_reset", cpu_reset, 1);
    checkOutput("rst_ld_ready", ld_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_cpu_go", cpu_go, 0);
    checkOutput("rst_chk_ready", chk_ready, 0);
    checkOutput("rst_reg_rd_idx", reg_rd_idx, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_timed_out", timed_out, 0);
    checkOutput("rst_load_trunc", load_trunc, 0);
    checkOutput("rst_fail_count", fail_count, 0);
    checkOutput("rst_first_fail_idx", first_fail_idx, 0);
  endtask

  // Runs one load/run/check sequence from the globals; abortRun resets mid-RUN.
  task automatic applyStimulus(input bit abortRun);
    res_t e;
    wr_t  ew;
    int   nW = 0;
    int   idx;
    int   guard;
    bit   fire;
    e.trunc = 0;
    for (int i = 0; i < prog.size(); i++) begin
      ew.addr = ADDR_W'(i);
      ew.data = prog[i];
      writeQ.push_back(ew);
      nW++;
      if (progHasLast && i == prog.size() - 1) break;
      if (nW == PROG_DEPTH) begin
        e.trunc = 1;
        break;
      end
    end
    e.writes = nW;
    e.tmo    = !(haltAt >= 0 && haltAt <= TIMEOUT - 1);
    e.fails  = 0;
    e.first  = 0;
    if (!e.tmo) begin
      foreach (chkList[i]) begin
        if (regs[chkList[i].idx] != chkList[i].expv) begin
          if (e.fails == 0) e.first = chkList[i].idx;
          if (e.fails < SAT) e.fails++;
        end
      end
    end
    e.pass    = !e.tmo && (e.fails == 0);
    e.latency = e.tmo ? TIMEOUT + 1 : -1;
    if (!abortRun) resultQ.push_back(e);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    idx = 0;
    guard = 0;
    while (idx < nW && guard < 500) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = prog[idx];
      ld_last  = progHasLast && (idx == prog.size() - 1);
      fire     = ld_valid && ld_ready;
      @(negedge clk);
      if (fire) idx++;
      guard++;
    end
    ld_valid = 1'b0;
    if (idx < nW) checkOutput("load_stall", idx, nW);
    checkOutput("ld_ready_after_last_word", ld_ready, 0);
    if (prog.size() > nW) begin
      ld_valid = 1'b1;
      ld_data  = prog[nW];
      ld_last  = 1'b0;
      repeat (3) @(negedge clk);
      ld_valid = 1'b0;
    end
    ld_last = 1'b0;

    if (abortRun) begin
      repeat (6) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkResetValues();
      checkOutput("abort_writes_pending", writeQ.size(), 0);
      writeQ.delete();
      reset = 1'b0;
      return;
    end

    if (startDuringRun) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    idx = 0;
    guard = 0;
    while (idx < chkList.size() && !done && guard < 3000) begin
      chk_valid  = ($urandom_range(0, 2) != 0);
      chk_idx    = chkList[idx].idx;
      chk_expect = chkList[idx].expv;
      chk_last   = (idx == chkList.size() - 1);
      fire       = chk_valid && chk_ready;
      @(negedge clk);
      if (fire) idx++;
      guard++;
    end
    chk_valid = 1'b0;
    chk_last  = 1'b0;

    guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      checkOutput("done_wait", 0, 1);
      resultQ.delete();
      writeQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic setArithProg();
    prog.delete();
    prog.push_back(32'h9EF10004);
    prog.push_back(32'h9EF20006);
    prog.push_back(32'h80801020);
    prog.push_back(32'hD0800010);
    progHasLast = 1;
  endtask

  task automatic addCheck(input int idx, input logic [DATA_W-1:0] v);
    chk_t c;
    c.idx  = REG_W'(idx);
    c.expv = v;
    chkList.push_back(c);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len;
    foreach (regs[i]) regs[i] = $urandom;
    regs[1] = 10; regs[2] = 6; regs[3] = 16; regs[4] = 10;

    repeat (3) @(negedge clk);
    checkResetValues();
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] arithmetic program");
    setArithProg();
    chkList.delete(); addCheck(1, 10);
    haltAt = 5; startDuringRun = 0;
    applyStimulus(0);

    $display("[TB] store/load program, halt at timeout boundary");
    prog.delete();
    prog.push_back(32'h9EF1000A); prog.push_back(32'h9EF20100);
    prog.push_back(32'hA0120000); prog.push_back(32'h00000000);
    prog.push_back(32'hB0420000); prog.push_back(32'h00000000);
    prog.push_back(32'hD0800010);
    progHasLast = 1;
    chkList.delete(); addCheck(1, 10); addCheck(4, 10);
    haltAt = TIMEOUT - 1;
    applyStimulus(0);

    $display("[TB] mismatching checks");
    setArithProg();
    chkList.delete(); addCheck(1, 10); addCheck(2, 7); addCheck(3, 9);
    haltAt = 0;
    applyStimulus(0);

    $display("[TB] timeout with ignored start");
    chkList.delete(); addCheck(1, 10);
    haltAt = -1; startDuringRun = 1;
    applyStimulus(0);
    startDuringRun = 0;

    $display("[TB] truncated load");
    prog.delete();
    for (int i = 0; i < PROG_DEPTH + 2; i++) prog.push_back($urandom);
    progHasLast = 0;
    haltAt = 3;
    applyStimulus(0);

    $display("[TB] last word exactly at depth");
    prog.delete();
    for (int i = 0; i < PROG_DEPTH; i++) prog.push_back($urandom);
    progHasLast = 1;
    applyStimulus(0);

    $display("[TB] fail counter saturation");
    setArithProg();
    chkList.delete();
    for (int i = 0; i < SAT + 3; i++) addCheck(i % 16, regs[i % 16] ^ 32'h1);
    haltAt = 2;
    applyStimulus(0);

    $display("[TB] reset during run, then a fresh sequence");
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back($urandom);
    progHasLast = 1;
    haltAt = -1;
    applyStimulus(1);
    setArithProg();
    chkList.delete(); addCheck(1, 10);
    haltAt = 4;
    applyStimulus(0);

    $display("[TB] randomized sequences");
    for (int run = 0; run < 20; run++) begin
      foreach (regs[i]) regs[i] = $urandom_range(0, 3);
      progHasLast = ($urandom_range(0, 3) != 0);
      len = progHasLast ? int'($urandom_range(1, PROG_DEPTH))
                        : int'($urandom_range(PROG_DEPTH, PROG_DEPTH + 2));
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back($urandom);
      case ($urandom_range(0, 3))
        0:       haltAt = -1;
        1:       haltAt = TIMEOUT - 1;
        default: haltAt = int'($urandom_range(0, TIMEOUT + 2));
      endcase
      chkList.delete();
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) addCheck(int'($urandom_range(0, 15)), $urandom_range(0, 3));
      startDuringRun = $urandom_range(0, 1) != 0;
      applyStimulus(0);
    end

    checkOutput("results_left_over", resultQ.size(), 0);
    checkOutput("writes_left_over", writeQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
